// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the register-file sequencing controller.
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_WR_IMM = 2'b00,
        OP_COPY   = 2'b01,
        OP_SWAP   = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR_A,
        S_WR_B,
        S_RSP
    } state_e;

endpackage

// File: rtl/regfile_seq_ctrl.sv
// Sequences WR_IMM / COPY / SWAP / READ commands onto the register file's
// combinational read port and clocked write port, one command at a time.
module regfile_seq_ctrl #(
    parameter int DATA_W = regfile_seq_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_seq_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rm,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data
);
    import regfile_seq_pkg::*;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [ADDR_W-1:0]  rm_q, rm_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0]  tmp_b_q, tmp_b_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic [ADDR_W-1:0]  r_addr_q, r_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_WR_IMM;
            rd_q       <= '0;
            rm_q       <= '0;
            imm_q      <= '0;
            tmp_a_q    <= '0;
            tmp_b_q    <= '0;
            rsp_data_q <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            r_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rm_q       <= rm_d;
            imm_q      <= imm_d;
            tmp_a_q    <= tmp_a_d;
            tmp_b_q    <= tmp_b_d;
            rsp_data_q <= rsp_data_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            r_addr_q   <= r_addr_d;
        end
    end

    // The *_d address/data values depend only on state and latched registers,
    // so driving the regfile ports from them keeps the outputs Moore while
    // the *_q copies make them hold their last value in unused states.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rm_d       = rm_q;
        imm_d      = imm_q;
        tmp_a_d    = tmp_a_q;
        tmp_b_d    = tmp_b_q;
        rsp_data_d = rsp_data_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        r_addr_d   = r_addr_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_w_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    rd_d    = cmd_rd;
                    rm_d    = cmd_rm;
                    imm_d   = cmd_imm;
                    state_d = (op_e'(cmd_op) == OP_WR_IMM) ? S_WR_A : S_RD_A;
                end
            end
            S_RD_A: begin
                r_addr_d = rm_q;
                tmp_a_d  = rf_r_data;
                case (op_q)
                    OP_SWAP: state_d = S_RD_B;
                    OP_COPY: state_d = S_WR_A;
                    default: state_d = S_RSP;
                endcase
            end
            S_RD_B: begin
                r_addr_d = rd_q;
                tmp_b_d  = rf_r_data;
                state_d  = S_WR_A;
            end
            S_WR_A: begin
                rf_w_en  = 1'b1;
                w_addr_d = rd_q;
                w_data_d = (op_q == OP_WR_IMM) ? imm_q : tmp_a_q;
                state_d  = (op_q == OP_SWAP) ? S_WR_B : S_RSP;
            end
            S_WR_B: begin
                rf_w_en  = 1'b1;
                w_addr_d = rm_q;
                w_data_d = tmp_b_q;
                state_d  = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Response value is captured once on RSP entry and held afterwards.
        if (state_d == S_RSP && state_q != S_RSP) begin
            case (op_q)
                OP_WR_IMM: rsp_data_d = imm_q;
                OP_SWAP:   rsp_data_d = tmp_b_d;
                default:   rsp_data_d = tmp_a_d;
            endcase
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rf_w_addr = w_addr_d;
    assign rf_w_data = w_data_d;
    assign rf_r_addr = r_addr_d;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Scoreboard bench: controller plus an 8x16 regfile model with combinational read.
module tb_regfile_seq_ctrl;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rm;
    logic [15:0] cmd_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rf_w_addr;
    logic [15:0] rf_w_data;
    logic        rf_w_en;
    logic [2:0]  rf_r_addr;
    logic [15:0] rf_r_data;

    logic [15:0] rf_mem [8];

    typedef struct {
        logic [15:0] data;
        int          start_cyc;
        int          lat;
        int          writes;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    bit   rsp_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
    assign rf_r_data = rf_mem[rf_r_addr];

    regfile_seq_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data), .rf_w_en(rf_w_en),
        .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: pops one expectation each time a response appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rf_w_en) wr_cnt++;
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got data %h expected no response", rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
                    chk("rsp_latency", cyc - e.start_cyc, e.lat);
                    chk("rf_writes", wr_cnt, e.writes);
                end
            end
            if (!rsp_valid) rsp_seen = 0;
        end
    end

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rm,
                         input logic [15:0] imm, input logic [15:0] exp_data,
                         input int exp_lat, input int exp_wr, input bit push);
        exp_t e;
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rm    = rm;
        cmd_imm   = imm;
        wr_cnt    = 0;
        if (push) begin
            e.data = exp_data; e.start_cyc = cyc; e.lat = exp_lat; e.writes = exp_wr;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rm,
                       input logic [15:0] imm, input logic [15:0] exp_data,
                       input int exp_lat, input int exp_wr);
        issue(op, rd, rm, imm, exp_data, exp_lat, exp_wr, 1'b1);
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = '0; cmd_rm = '0;
        cmd_imm = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_w_en", {31'h0, rf_w_en}, 32'h0);
        chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
        chk("rst_w_addr_r_addr", {26'h0, rf_w_addr, rf_r_addr}, 32'h0);
        chk("rst_w_data", {16'h0, rf_w_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) txn(OP_WR_IMM, 3'(i), 3'd0, 16'h0, 16'h0, 2, 1);

        txn(OP_WR_IMM, 3'd0, 3'd0, 16'd5030, 16'd5030, 2, 1);
        txn(OP_READ,   3'd0, 3'd0, 16'h0,    16'd5030, 2, 0);

        txn(OP_WR_IMM, 3'd5, 3'd0, 16'hFFE2, 16'hFFE2, 2, 1);
        txn(OP_COPY,   3'd7, 3'd5, 16'h0,    16'hFFE2, 3, 1);
        chk("r7_after_copy", {16'h0, rf_mem[7]}, 32'hFFE2);
        txn(OP_READ,   3'd0, 3'd7, 16'h0,    16'hFFE2, 2, 0);
        txn(OP_COPY,   3'd5, 3'd5, 16'h0,    16'hFFE2, 3, 1);
        chk("r5_copy_self", {16'h0, rf_mem[5]}, 32'hFFE2);

        txn(OP_WR_IMM, 3'd2, 3'd0, 16'h7FFF, 16'h7FFF, 2, 1);
        txn(OP_WR_IMM, 3'd3, 3'd0, 16'h8000, 16'h8000, 2, 1);
        txn(OP_SWAP,   3'd2, 3'd3, 16'h0,    16'h7FFF, 5, 2);
        chk("r2_after_swap", {16'h0, rf_mem[2]}, 32'h8000);
        chk("r3_after_swap", {16'h0, rf_mem[3]}, 32'h7FFF);
        txn(OP_SWAP,   3'd2, 3'd2, 16'h0,    16'h8000, 5, 2);
        chk("r2_swap_self", {16'h0, rf_mem[2]}, 32'h8000);

        // Back-pressure: response must hold and stray commands must be ignored.
        rsp_ready = 1'b0;
        issue(OP_READ, 3'd0, 3'd3, 16'h0, 16'h7FFF, 2, 0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rsp_data", {16'h0, rsp_data}, 32'h7FFF);
            chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            cmd_valid = 1'b1; cmd_op = OP_WR_IMM; cmd_rd = 3'd0; cmd_imm = 16'h1234;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
        chk("bp_rsp_data_hold", {16'h0, rsp_data}, 32'h7FFF);
        chk("bp_r0_untouched", {16'h0, rf_mem[0]}, 32'd5030);
        wait_idle();

        // Reset while in WR_B of a SWAP: WR_A commit survives, WR_B never happens.
        txn(OP_WR_IMM, 3'd4, 3'd0, 16'd1, 16'd1, 2, 1);
        txn(OP_WR_IMM, 3'd6, 3'd0, 16'd2, 16'd2, 2, 1);
        issue(OP_SWAP, 3'd4, 3'd6, 16'h0, 16'h0, 5, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_swap_wr_b_en", {31'h0, rf_w_en}, 32'h1);
        chk("mid_swap_wr_b_addr", {29'h0, rf_w_addr}, 32'd6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst_w_en", {31'h0, rf_w_en}, 32'h0);
        chk("mid_rst_rsp_data", {16'h0, rsp_data}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_r4", {16'h0, rf_mem[4]}, 32'd2);
        chk("mid_rst_r6", {16'h0, rf_mem[6]}, 32'd2);
        @(negedge clk);
        txn(OP_READ, 3'd0, 3'd4, 16'h0, 16'd2, 2, 0);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
